// File: rtl/jenc_stuff_packer.sv
// jenc_stuff_packer: JPEG entropy-stream 0xFF stuffer and fixed-width word packer.
// Stage 1 stuffs one input beat; stage 2 packs the stuffed bytes into OUT_BYTES words.
module jenc_stuff_packer #(
  parameter int IN_BYTES   = 8,
  parameter int OUT_BYTES  = 16,
  parameter int STUFF_EN   = 1,
  parameter int APPEND_EOI = 0,
  parameter int SIZE_W     = 20
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [8*IN_BYTES-1:0]          in_data,
  input  logic [$clog2(IN_BYTES+1)-1:0]  in_bytes,
  input  logic                           in_tlast,
  input  logic                           in_valid,
  output logic                           in_hold,
  output logic [8*OUT_BYTES-1:0]         out_data,
  output logic [$clog2(OUT_BYTES+1)-1:0] out_bytes,
  output logic                           out_tlast,
  output logic                           out_valid,
  input  logic                           out_hold,
  output logic [SIZE_W-1:0]              size,
  input  logic                           size_clear
);
  localparam int IBW   = $clog2(IN_BYTES+1);
  localparam int OBW   = $clog2(OUT_BYTES+1);
  localparam int S1_B  = 2*IN_BYTES;
  localparam int S1_W  = 8*S1_B;
  localparam int SBW   = $clog2(S1_B+1);
  localparam int ACC_B = 2*OUT_BYTES+2;
  localparam int ACC_W = 8*ACC_B;
  localparam int CW    = $clog2(ACC_B+1);
  localparam int OUT_W = 8*OUT_BYTES;

  generate
    if (OUT_BYTES < 2*IN_BYTES) begin : g_bad_cfg
      $error("jenc_stuff_packer: OUT_BYTES must be at least 2*IN_BYTES");
    end
  endgenerate

  typedef enum logic {RUN, DRAIN} state_t;

  state_t             state_reg;
  logic               s1_valid_reg;
  logic [S1_W-1:0]    s1_data_reg;
  logic [SBW-1:0]     s1_bytes_reg;
  logic               s1_last_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [CW-1:0]      cnt_reg;
  logic               out_valid_reg;
  logic               out_tlast_reg;
  logic [OBW-1:0]     out_bytes_reg;
  logic [OUT_W-1:0]   out_data_reg;
  logic [SIZE_W-1:0]  size_reg;
  logic [SIZE_W-1:0]  size_cnt_reg;
  logic [1:0]         clr_sync_reg;

  logic               accept;
  logic [7:0]         in_byte [IN_BYTES];
  logic [IN_BYTES-1:0] byte_vld;
  logic [IN_BYTES-1:0] byte_ff;
  logic [S1_W-1:0]    st_data;
  logic [SBW-1:0]     st_bytes;

  logic [ACC_W-1:0]   merged;
  logic [CW-1:0]      total;
  logic               emit;
  logic               emit_last;
  logic [OBW-1:0]     emit_n;
  logic [OUT_W-1:0]   word;

  assign in_hold   = out_hold | (state_reg == DRAIN);
  assign accept    = in_valid & ~in_hold;
  assign out_data  = out_data_reg;
  assign out_bytes = out_bytes_reg;
  assign out_tlast = out_tlast_reg;
  assign out_valid = out_valid_reg;
  assign size      = size_reg;

  for (genvar gi = 0; gi < IN_BYTES; gi++) begin : g_bytes
    assign in_byte[gi]  = in_data[8*(IN_BYTES-gi)-1 -: 8];
    assign byte_vld[gi] = (IBW'(gi) < in_bytes);
    assign byte_ff[gi]  = (STUFF_EN != 0) && (in_byte[gi] == 8'hFF);
  end

  // Stuffed zero bytes come for free: st_data starts cleared and 0xFF just skips a slot.
  always_comb begin
    st_data  = '0;
    st_bytes = '0;
    for (int i = 0; i < IN_BYTES; i++) begin
      if (byte_vld[i]) begin
        st_data[S1_W-1-8*st_bytes -: 8] = in_byte[i];
        st_bytes = st_bytes + (byte_ff[i] ? SBW'(2) : SBW'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_bytes_reg <= '0;
      s1_last_reg  <= 1'b0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_data_reg  <= st_data;
      s1_bytes_reg <= st_bytes;
      s1_last_reg  <= in_tlast;
    end else if (!out_hold && state_reg == RUN) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // Accumulator bytes beyond cnt_reg are always zero, so appending is a shift-and-OR.
  always_comb begin
    merged    = acc_reg;
    total     = cnt_reg;
    emit      = 1'b0;
    emit_last = 1'b0;
    emit_n    = '0;
    if (state_reg == DRAIN) begin
      emit = 1'b1;
      if (cnt_reg <= CW'(OUT_BYTES)) begin
        emit_n    = OBW'(cnt_reg);
        emit_last = 1'b1;
      end else begin
        emit_n = OBW'(OUT_BYTES);
      end
    end else if (s1_valid_reg) begin
      merged = acc_reg | ({s1_data_reg, {(ACC_W-S1_W){1'b0}}} >> {cnt_reg, 3'b000});
      total  = cnt_reg + CW'(s1_bytes_reg);
      if (APPEND_EOI != 0 && s1_last_reg) begin
        merged = merged | ({16'hFFD9, {(ACC_W-16){1'b0}}} >> {total, 3'b000});
        total  = total + CW'(2);
      end
      if (s1_last_reg) begin
        emit = 1'b1;
        if (total <= CW'(OUT_BYTES)) begin
          emit_n    = OBW'(total);
          emit_last = 1'b1;
        end else begin
          emit_n = OBW'(OUT_BYTES);
        end
      end else if (total >= CW'(OUT_BYTES)) begin
        emit   = 1'b1;
        emit_n = OBW'(OUT_BYTES);
      end
    end
    word = merged[ACC_W-1 -: OUT_W] & ~({OUT_W{1'b1}} >> {emit_n, 3'b000});
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= RUN;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_tlast_reg <= 1'b0;
      out_bytes_reg <= '0;
      out_data_reg  <= '0;
    end else if (!out_hold) begin
      out_valid_reg <= emit;
      out_tlast_reg <= emit_last;
      out_bytes_reg <= emit_n;
      out_data_reg  <= word;
      if (emit_last) begin
        acc_reg   <= '0;
        cnt_reg   <= '0;
        state_reg <= RUN;
      end else if (emit) begin
        acc_reg   <= merged << OUT_W;
        cnt_reg   <= total - CW'(OUT_BYTES);
        state_reg <= (state_reg == DRAIN || s1_last_reg) ? DRAIN : RUN;
      end else begin
        acc_reg <= merged;
        cnt_reg <= total;
      end
    end
  end

  // size_clear arrives from another domain; the synchronised request beats a frame update.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clr_sync_reg <= 2'b00;
      size_reg     <= '0;
      size_cnt_reg <= '0;
    end else begin
      clr_sync_reg <= {clr_sync_reg[0], size_clear};
      if (out_valid_reg && !out_hold) begin
        if (out_tlast_reg) begin
          size_cnt_reg <= '0;
          if (!clr_sync_reg[1]) size_reg <= size_cnt_reg + SIZE_W'(out_bytes_reg);
        end else begin
          size_cnt_reg <= size_cnt_reg + SIZE_W'(out_bytes_reg);
        end
      end
      if (clr_sync_reg[1]) size_reg <= '0;
    end
  end
endmodule

// File: tb/tb_jenc_stuff_packer.sv
// Scoreboard bench for jenc_stuff_packer: dut0 without EOI, dut1 with EOI appended.
module tb_jenc_stuff_packer;
  localparam int OB = 16;

  typedef struct {
    logic [127:0] data;
    int           bytes;
    bit           last;
    int           fsize;
  } exp_t;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic [1:0][63:0]    in_data;
  logic [1:0][3:0]     in_bytes;
  logic [1:0]          in_tlast;
  logic [1:0]          in_valid;
  logic [1:0]          in_hold;
  logic [1:0][127:0]   out_data;
  logic [1:0][4:0]     out_bytes;
  logic [1:0]          out_tlast;
  logic [1:0]          out_valid;
  logic [1:0]          out_hold;
  logic [1:0][19:0]    frame_size;
  logic [1:0]          size_clear;

  int   n_checks = 0;
  int   n_fail = 0;
  int   hold_mode [2];
  int   fbytes [2];
  logic [7:0] mq [2][$];
  exp_t exp_q [2][$];

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    jenc_stuff_packer #(
      .IN_BYTES(8), .OUT_BYTES(16), .STUFF_EN(1), .APPEND_EOI(gi), .SIZE_W(20)
    ) u_dut (
      .clk(clk), .resetn(resetn),
      .in_data(in_data[gi]), .in_bytes(in_bytes[gi]), .in_tlast(in_tlast[gi]),
      .in_valid(in_valid[gi]), .in_hold(in_hold[gi]),
      .out_data(out_data[gi]), .out_bytes(out_bytes[gi]), .out_tlast(out_tlast[gi]),
      .out_valid(out_valid[gi]), .out_hold(out_hold[gi]),
      .size(frame_size[gi]), .size_clear(size_clear[gi])
    );

    exp_t e;
    bit   sz_pend;
    int   sz_exp;

    initial begin : mon
      sz_pend = 1'b0;
      forever begin
        @(negedge clk);
        if (!resetn) begin
          sz_pend = 1'b0;
        end else begin
          if (sz_pend) begin
            check($sformatf("dut%0d frame size", gi), 128'(frame_size[gi]), 128'(sz_exp));
            sz_pend = 1'b0;
          end
          if (out_valid[gi] && !out_hold[gi]) begin
            if (exp_q[gi].size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL dut%0d extra word: got bytes=%0d data=%h, required no word",
                       gi, out_bytes[gi], out_data[gi]);
            end else begin
              e = exp_q[gi].pop_front();
              $display("dut%0d word bytes=%0d last=%0b data=%h", gi, out_bytes[gi], out_tlast[gi], out_data[gi]);
              check($sformatf("dut%0d out_data", gi), out_data[gi], e.data);
              check($sformatf("dut%0d out_bytes", gi), 128'(out_bytes[gi]), 128'(e.bytes));
              check($sformatf("dut%0d out_tlast", gi), 128'(out_tlast[gi]), 128'(e.last));
              if (e.last) begin
                sz_pend = 1'b1;
                sz_exp  = e.fsize;
              end
            end
          end
        end
      end
    end
  end

  // Single driver for out_hold: off, random 25 %, or forced high.
  initial forever begin
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      out_hold[d] = (hold_mode[d] == 2) || (hold_mode[d] == 1 && $urandom_range(99) < 25);
  end

  function automatic logic [7:0] rbyte(input int ffpct);
    if ($urandom_range(99) < ffpct) return 8'hFF;
    return 8'($urandom_range(254));
  endfunction

  function automatic logic [63:0] rbeat(input int ffpct);
    logic [63:0] b;
    for (int i = 0; i < 8; i++) b[63-8*i -: 8] = rbyte(ffpct);
    return b;
  endfunction

  task automatic push_word(input int d, input int n, input bit last);
    exp_t w;
    w.data = '0;
    for (int i = 0; i < n; i++) w.data[127-8*i -: 8] = mq[d].pop_front();
    w.bytes = n;
    w.last  = last;
    w.fsize = last ? fbytes[d] : 0;
    exp_q[d].push_back(w);
  endtask

  // Reference: a frame is its stuffed byte stream (plus EOI); whole words leave as soon
  // as they fill, and at tlast everything left is cut into words with the final one marked.
  task automatic model_beat(input int d, input logic [63:0] data, input int n, input bit last);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = data[63-8*i -: 8];
      mq[d].push_back(b);
      fbytes[d]++;
      if (b == 8'hFF) begin
        mq[d].push_back(8'h00);
        fbytes[d]++;
      end
    end
    if (last) begin
      if (d == 1) begin
        mq[d].push_back(8'hFF);
        mq[d].push_back(8'hD9);
        fbytes[d] += 2;
      end
      while (mq[d].size() > OB) push_word(d, OB, 1'b0);
      push_word(d, mq[d].size(), 1'b1);
      fbytes[d] = 0;
    end else begin
      while (mq[d].size() >= OB) push_word(d, OB, 1'b0);
    end
  endtask

  task automatic send(input int d, input logic [63:0] data, input int n, input bit last);
    int waitc;
    in_data[d]  = data;
    in_bytes[d] = 4'(n);
    in_tlast[d] = last;
    in_valid[d] = 1'b1;
    waitc = 0;
    @(negedge clk);
    while (in_hold[d] && waitc < 500) begin
      waitc++;
      @(negedge clk);
    end
    if (waitc >= 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut%0d beat accept: got in_hold stuck 1, required 0 within 500 cycles", d);
    end
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    if (waitc < 500) model_beat(d, data, n, last);
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d/%0d words pending, required 0", exp_q[0].size(), exp_q[1].size());
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hold_cnt;
    int nb;
    hold_mode[0] = 0;
    hold_mode[1] = 0;
    fbytes[0] = 0;
    fbytes[1] = 0;
    in_data = '0;
    in_bytes = '0;
    in_tlast = '0;
    in_valid = '0;
    size_clear = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d reset out_valid", d), 128'(out_valid[d]), 128'(0));
      check($sformatf("dut%0d reset out_bytes", d), 128'(out_bytes[d]), 128'(0));
      check($sformatf("dut%0d reset out_data", d), out_data[d], 128'(0));
      check($sformatf("dut%0d reset size", d), 128'(frame_size[d]), 128'(0));
      check($sformatf("dut%0d reset in_hold", d), 128'(in_hold[d]), 128'(0));
    end
    @(posedge clk);
    #1;

    // 19-byte frame without 0xFF
    send(0, rbeat(0), 8, 1'b0);
    send(0, rbeat(0), 8, 1'b0);
    send(0, rbeat(0), 3, 1'b1);
    wait_drain();
    check("t1 size", 128'(frame_size[0]), 128'(19));

    // eight 0xFF bytes stuffed into one full word
    send(0, 64'hFFFF_FFFF_FFFF_FFFF, 8, 1'b1);
    wait_drain();
    check("t2 size", 128'(frame_size[0]), 128'(16));

    // 15-byte residual, then eight 0xFF plus EOI: 33 bytes with a two-cycle drain
    send(1, rbeat(0), 8, 1'b0);
    send(1, rbeat(0), 7, 1'b0);
    send(1, 64'hFFFF_FFFF_FFFF_FFFF, 8, 1'b1);
    hold_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (in_hold[1]) hold_cnt++;
    end
    check("t3 drain in_hold cycles", 128'(hold_cnt), 128'(2));
    wait_drain();
    check("t3 size", 128'(frame_size[1]), 128'(33));

    // downstream stall while a word is presented
    send(0, rbeat(30), 8, 1'b0);
    send(0, rbeat(30), 8, 1'b0);
    hold_mode[0] = 2;
    repeat (5) @(negedge clk);
    check("t4 held out_valid", 128'(out_valid[0]), 128'(1));
    check("t4 held in_hold", 128'(in_hold[0]), 128'(1));
    @(posedge clk);
    #1 hold_mode[0] = 0;
    send(0, rbeat(30), 3, 1'b1);
    wait_drain();

    // empty frames
    send(0, rbeat(30), 0, 1'b1);
    send(1, rbeat(30), 0, 1'b1);
    wait_drain();

    // randomised frames with random downstream stalls
    for (int d = 0; d < 2; d++) begin
      hold_mode[d] = 1;
      for (int f = 0; f < 30; f++) begin
        nb = $urandom_range(1, 4);
        for (int b = 0; b < nb; b++) begin
          send(d, rbeat(25), $urandom_range(0, 8), b == nb - 1);
          if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
      end
      wait_drain();
      hold_mode[d] = 0;
    end
    wait_drain();

    // asynchronous reset with a word waiting on dut0
    send(0, rbeat(0), 8, 1'b0);
    send(0, rbeat(0), 8, 1'b0);
    hold_mode[0] = 2;
    repeat (3) @(negedge clk);
    check("t6 pre-reset out_valid", 128'(out_valid[0]), 128'(1));
    #2 resetn = 1'b0;
    #1;
    check("t6 reset out_valid", 128'(out_valid[0]), 128'(0));
    check("t6 reset out_bytes", 128'(out_bytes[0]), 128'(0));
    mq[0].delete();
    exp_q[0].delete();
    fbytes[0] = 0;
    hold_mode[0] = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    send(0, rbeat(0), 8, 1'b0);
    send(0, rbeat(0), 8, 1'b0);
    send(0, rbeat(0), 3, 1'b1);
    wait_drain();
    check("t6 size after reset", 128'(frame_size[0]), 128'(19));
    size_clear[0] = 1'b1;
    @(posedge clk);
    #1 size_clear[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t6 size_clear", 128'(frame_size[0]), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
